// File: rtl/vector_scale_pkg.sv
// Shared types, default parameters and constant helpers for the vector scaler.
package vector_scale_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_VECTOR_SIZE = 5;
  localparam int unsigned DEF_CELL_WIDTH  = 8;
  localparam int unsigned DEF_SCALE_WIDTH = 8;
  localparam int unsigned DEF_SHIFT       = 4;
  localparam int unsigned DEF_TILING      = 1;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(n)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Largest positive value of a signed field of width w.
  function automatic int sat_max(input int unsigned w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Most negative value of a signed field of width w.
  function automatic int sat_min(input int unsigned w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/vector_scale_if.sv
// Start/finish handshake and vector payload between a requester and vector_scale.
interface vector_scale_if
  import vector_scale_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int unsigned CELL_WIDTH  = DEF_CELL_WIDTH,
  parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH
);

  logic                              start;
  logic [VECTOR_SIZE*CELL_WIDTH-1:0] vector;
  logic [SCALE_WIDTH-1:0]            scale;
  logic [VECTOR_SIZE*CELL_WIDTH-1:0] result;
  logic                              busy;
  logic                              saturated;
  logic                              finish;

  modport master (
    output start, vector, scale,
    input  result, busy, saturated, finish
  );

  modport slave (
    input  start, vector, scale,
    output result, busy, saturated, finish
  );

endinterface

// File: rtl/scale_cell.sv
// One element: signed multiply, floor arithmetic shift, saturate to CELL_WIDTH.
module scale_cell
  import vector_scale_pkg::*;
#(
  parameter int unsigned CELL_WIDTH  = DEF_CELL_WIDTH,
  parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int unsigned SHIFT       = DEF_SHIFT
) (
  input  logic signed [CELL_WIDTH-1:0]  v,
  input  logic signed [SCALE_WIDTH-1:0] s,
  output logic signed [CELL_WIDTH-1:0]  q,
  output logic                          clipped
);

  localparam int unsigned PW = CELL_WIDTH + SCALE_WIDTH;
  localparam logic signed [PW-1:0] HI = PW'(sat_max(CELL_WIDTH));
  localparam logic signed [PW-1:0] LO = PW'(sat_min(CELL_WIDTH));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // Full-width product cannot overflow; >>> on a signed value floors.
  always_comb begin
    prod    = PW'(v) * PW'(s);
    shifted = prod >>> SHIFT;
    q       = shifted[CELL_WIDTH-1:0];
    clipped = 1'b0;
    if (shifted > HI) begin
      q       = HI[CELL_WIDTH-1:0];
      clipped = 1'b1;
    end else if (shifted < LO) begin
      q       = LO[CELL_WIDTH-1:0];
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/vector_scale.sv
// Sequential element-wise scaler: TILING elements per cycle from latched operands.
module vector_scale
  import vector_scale_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int unsigned CELL_WIDTH  = DEF_CELL_WIDTH,
  parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int unsigned SHIFT       = DEF_SHIFT,
  parameter int unsigned TILING      = DEF_TILING
) (
  input logic          clk,
  input logic          rst,
  vector_scale_if.slave bus
);

  localparam int unsigned CNT_W = clog2(VECTOR_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VECTOR_SIZE - TILING);

  generate
    if ((VECTOR_SIZE % TILING) != 0) begin : g_tiling_check
      $error("vector_scale: VECTOR_SIZE must be a multiple of TILING");
    end
  endgenerate

  state_t state_q, state_d;
  logic   load, step, done;

  logic [CNT_W-1:0]                        cnt_q;
  logic [VECTOR_SIZE-1:0][CELL_WIDTH-1:0]  vec_q;
  logic [VECTOR_SIZE-1:0][CELL_WIDTH-1:0]  res_q;
  logic [SCALE_WIDTH-1:0]                  scale_q;
  logic                                    sat_q;
  logic                                    finish_q;
  logic [TILING-1:0][CELL_WIDTH-1:0]       tile_q;
  logic [TILING-1:0]                       tile_clip;

  // One arithmetic cell per tile lane, fed from the latched operands.
  generate
    for (genvar t = 0; t < TILING; t++) begin : g_cell
      scale_cell #(
        .CELL_WIDTH (CELL_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH),
        .SHIFT      (SHIFT)
      ) u_cell (
        .v      (vec_q[cnt_q + CNT_W'(t)]),
        .s      (scale_q),
        .q      (tile_q[t]),
        .clipped(tile_clip[t])
      );
    end
  endgenerate

  // Next state: accept start only in IDLE, leave RUN on the last tile.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand latches, tile counter, result buffer and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      vec_q    <= '0;
      scale_q  <= '0;
      res_q    <= '0;
      sat_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= done;
      if (load) begin
        vec_q   <= bus.vector;
        scale_q <= bus.scale;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
      end else if (step) begin
        for (int t = 0; t < TILING; t++) begin
          res_q[cnt_q + CNT_W'(t)] <= tile_q[t];
        end
        sat_q <= sat_q | (|tile_clip);
        cnt_q <= done ? '0 : cnt_q + CNT_W'(TILING);
      end
    end
  end

  assign bus.result    = res_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.saturated = sat_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_vector_scale.sv
// Directed bench for vector_scale with a cycle-level reference model.
module tb_vector_scale;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  vector_scale_if #(.VECTOR_SIZE(5), .CELL_WIDTH(8), .SCALE_WIDTH(8)) bus ();
  vector_scale_if #(.VECTOR_SIZE(5), .CELL_WIDTH(8), .SCALE_WIDTH(8)) bus5 ();

  vector_scale #(
    .VECTOR_SIZE(5), .CELL_WIDTH(8), .SCALE_WIDTH(8), .SHIFT(4), .TILING(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  vector_scale #(
    .VECTOR_SIZE(5), .CELL_WIDTH(8), .SCALE_WIDTH(8), .SHIFT(4), .TILING(5)
  ) dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] pack5(input int a, input int b, input int c,
                                        input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // floor(v*s / 16) computed by exact division, independent of shifts.
  function automatic int floor_scaled(input int v, input int s);
    int p, m;
    p = v * s;
    m = ((p % 16) + 16) % 16;
    return (p - m) / 16;
  endfunction

  // Reference model: a run takes 5 edges after acceptance, then result is final.
  int          rem = 0;
  bit          fin_exp = 0;
  bit          valid = 0;
  logic [39:0] exp_res = '0;
  bit          exp_sat = 0;

  always @(posedge clk or negedge rst) begin
    logic signed [7:0] e;
    logic signed [7:0] sc;
    int q;
    if (!rst) begin
      rem = 0; fin_exp = 0; valid = 0;
    end else begin
      fin_exp = 0;
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          fin_exp = 1;
          valid   = 1;
        end
      end else if (bus.start) begin
        sc = bus.scale;
        exp_sat = 0;
        for (int i = 0; i < 5; i++) begin
          e = bus.vector[i*8 +: 8];
          q = floor_scaled(int'(e), int'(sc));
          if (q > 127) begin q = 127; exp_sat = 1; end
          else if (q < -128) begin q = -128; exp_sat = 1; end
          exp_res[i*8 +: 8] = 8'(q);
        end
        rem   = 5;
        valid = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("busy", 64'(bus.busy), 64'(rem > 0));
      check("finish", 64'(bus.finish), 64'(fin_exp));
      if (valid) begin
        check("model_result", 64'(bus.result), 64'(exp_res));
        check("model_saturated", 64'(bus.saturated), 64'(exp_sat));
      end
    end
  end

  task automatic run_vec(input int a, input int b, input int c, input int d,
                         input int e, input int s, output int busy_cnt, output bit seen);
    bus.vector = pack5(a, b, c, d, e);
    bus.scale  = 8'(s);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    seen      = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.finish) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check("finish_seen", 64'(seen), 64'(1));
  endtask

  initial begin
    int  bc;
    bit  seen;
    int  fin_cnt;

    bus.start = 1'b0;  bus.vector = '0;  bus.scale = '0;
    bus5.start = 1'b0; bus5.vector = '0; bus5.scale = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_finish", 64'(bus.finish), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_saturated", 64'(bus.saturated), 64'(0));
    check("rst_result5", 64'(bus5.result), 64'(0));
    #2 rst = 1'b1;
    @(negedge clk);

    // Basic: unity scale
    run_vec(16, -16, 100, 0, 1, 16, bc, seen);
    check("basic_result", 64'(bus.result), 64'(pack5(16, -16, 100, 0, 1)));
    check("basic_sat", 64'(bus.saturated), 64'(0));
    check("basic_busy_cycles", 64'(bc), 64'(5));
    @(negedge clk);

    // Saturation, then a back-to-back run that clears it
    run_vec(100, -100, 7, 0, 0, 64, bc, seen);
    check("sat_result", 64'(bus.result), 64'(pack5(127, -128, 28, 0, 0)));
    check("sat_flag", 64'(bus.saturated), 64'(1));
    run_vec(3, -3, 50, -50, 8, 16, bc, seen);
    check("b2b_result", 64'(bus.result), 64'(pack5(3, -3, 50, -50, 8)));
    check("b2b_sat_cleared", 64'(bus.saturated), 64'(0));
    check("b2b_busy_cycles", 64'(bc), 64'(5));
    @(negedge clk);

    // Floor rounding
    run_vec(-1, 1, -17, 17, 0, 1, bc, seen);
    check("round_result", 64'(bus.result), 64'(pack5(-1, 0, -2, 1, 0)));
    repeat (2) @(negedge clk);
    check("hold_result", 64'(bus.result), 64'(pack5(-1, 0, -2, 1, 0)));

    // start held and vector scrambled during RUN
    bus.vector = pack5(10, 20, 30, 40, 50);
    bus.scale  = 8'(16);
    bus.start  = 1'b1;
    fin_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.vector = 40'({$urandom, $urandom});
      bus.scale  = 8'($urandom);
      if (bus.finish) begin
        fin_cnt++;
        bus.start = 1'b0;
        check("held_result", 64'(bus.result), 64'(pack5(10, 20, 30, 40, 50)));
        break;
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.finish) fin_cnt++;
    end
    check("held_finish_count", 64'(fin_cnt), 64'(1));
    check("held_idle", 64'(bus.busy), 64'(0));

    // Reset in the third RUN cycle
    bus.vector = pack5(9, 9, 9, 9, 9);
    bus.scale  = 8'(16);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_finish", 64'(bus.finish), 64'(0));
    check("midrst_result", 64'(bus.result), 64'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run_vec(1, 2, 3, 4, 5, 16, bc, seen);
    check("postrst_result", 64'(bus.result), 64'(pack5(1, 2, 3, 4, 5)));
    check("postrst_busy_cycles", 64'(bc), 64'(5));

    // Full tiling: whole vector in one RUN edge
    @(negedge clk);
    bus5.vector = pack5(1, 2, 3, 4, 5);
    bus5.scale  = 8'(32);
    bus5.start  = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    check("tile5_busy", 64'(bus5.busy), 64'(1));
    check("tile5_no_early_finish", 64'(bus5.finish), 64'(0));
    @(negedge clk);
    check("tile5_finish", 64'(bus5.finish), 64'(1));
    check("tile5_busy_drop", 64'(bus5.busy), 64'(0));
    check("tile5_result", 64'(bus5.result), 64'(pack5(2, 4, 6, 8, 10)));
    check("tile5_sat", 64'(bus5.saturated), 64'(0));
    @(negedge clk);
    check("tile5_finish_pulse", 64'(bus5.finish), 64'(0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_scale.md
Name: vector_scale

Overview:
Element-wise scaler that multiplies a signed vector by a signed scalar, arithmetic-right-shifts each product by a fixed amount, and saturates it back to CELL_WIDTH. It sits directly upstream of vector_add in the backpropagation weight-update path, producing lr*delta terms that vector_add sums with the current weights. Processing is sequential: TILING elements per cycle under a start/finish handshake, with the same tiled-counter flavour as vector_add.

Parameters:
VECTOR_SIZE, 5, number of elements in the vector
CELL_WIDTH, 8, width of each signed input and output element
SCALE_WIDTH, 8, width of the signed scalar
SHIFT, 4, arithmetic right shift applied to each product (fixed-point scale)
TILING, 1, elements processed per cycle; VECTOR_SIZE % TILING must be 0 (elaboration-time check)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request a run; sampled only in IDLE
vector  input  VECTOR_SIZE*CELL_WIDTH  signed elements, element i at [i*CELL_WIDTH +: CELL_WIDTH]
scale  input  SCALE_WIDTH  signed scalar multiplier
result  output  VECTOR_SIZE*CELL_WIDTH  signed scaled elements, same packing as vector
busy  output  1  high while in RUN
saturated  output  1  high if any element of the current or last run was clipped
finish  output  1  one-cycle pulse when result is complete

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counter=0, operand latches=0, result=0, busy=0, saturated=0, finish=0.
- States: IDLE and RUN.
- IDLE with start=1 at edge k:
  - Latch vector and scale into internal registers.
  - Clear saturated and the counter.
  - Enter RUN; busy=1 from edge k.
- RUN: each edge writes TILING results from latched operands at counter..counter+TILING-1, then counter += TILING.
  - The edge that writes the last tile returns to IDLE, sets finish=1 for exactly one cycle and drops busy.
  - With N = VECTOR_SIZE/TILING, finish is high during the cycle after edge k+N. For TILING=VECTOR_SIZE, finish follows edge k+1.
- Per-element arithmetic (all signed two's complement):
  - p = v*s, full width CELL_WIDTH+SCALE_WIDTH.
  - q = p >>> SHIFT, floor rounding with no rounding bias.
  - If q > 2^(CELL_WIDTH-1)-1, output the max positive value; if q < -2^(CELL_WIDTH-1), output the min negative value; otherwise output q truncated to CELL_WIDTH.
  - Any clip sets saturated, which is sticky until the next accepted start.
- start while in RUN is ignored. Changes to vector or scale during RUN have no effect, because the latched copies are used.
- result holds its value after finish until overwritten tile by tile by the next run. result is only guaranteed complete from the finish cycle until the next accepted start.
- If start=1 in the same cycle that finish is high, state is IDLE, so the new run is accepted.
- Reset asserted mid-run aborts immediately to reset values. No finish is produced.

Decomposition:
- Shared package:
  - IDLE/RUN state constants.
  - A log2/clog2 function used for the counter width.
  - Saturation-limit helper constants derived from CELL_WIDTH.
- Sub-module scale_cell: combinational multiply, shift and saturate for one element, with ports v, s, q, clipped. Instantiated TILING times in a generate loop. The top module holds the FSM, counter, operand latches and result buffer.

Test Plan:
All scenarios use CELL_WIDTH=8, SCALE_WIDTH=8, SHIFT=4, VECTOR_SIZE=5, TILING=1 unless noted.
1. Basic: vector=[16,-16,100,0,1], scale=16, start pulse -> after 5 RUN cycles finish pulses once; result=[16,-16,100,0,1], saturated=0, busy high exactly 5 cycles.
2. Saturation: vector=[100,-100,7,0,0], scale=64 -> result=[127,-128,28,0,0], saturated=1; the next run with scale=16 clears saturated to 0.
3. Rounding: vector=[-1,1,-17,17,0], scale=1 -> result=[-1,0,-2,1,0] (floor behaviour).
4. Ignored start and operand stability: start held high and vector changed every cycle during RUN -> a single run completes using the latched values, with exactly one finish pulse; a new run starts only from IDLE.
5. Reset mid-run: rst low at cycle 3 of RUN -> busy=0, finish=0, result=0 immediately (asynchronous); a subsequent start completes normally.
6. TILING=5: vector=[1,2,3,4,5], scale=32 -> finish in the cycle after the first RUN edge; result=[2,4,6,8,10].
